// File: rtl/mem_access_unit.sv
// mem_access_unit -- load/store unit between the execute stage and a
// single-outstanding-request data bus.
//
// Memory aluops are turned into one bus transaction (IDLE -> BUSY -> DONE)
// while the pipeline is held with stallreq_o. Non-memory aluops pass the
// write-back bundle straight through.
//
// Ports
//   clk, rst (async, active-low)
//   aluop_i, mem_addr_i, reg2_i          : operation, effective address, store data
//   wd_i, wreg_i, wdata_i                : register write-back bundle in
//   hi_i, lo_i, whilo_i                  : HI/LO bundle in (passed through)
//   d_req_o, d_we_o, d_addr_o,
//   d_sel_o, d_wdata_o                   : data-bus request side
//   d_ack_i, d_rdata_i                   : data-bus completion side
//   wd_o, wreg_o, wdata_o,
//   hi_o, lo_o, whilo_o                  : write-back bundle out
//   stallreq_o                           : pipeline hold
//   misalign_o, bus_err_o                : one-cycle exception pulses
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255,   // must be >= 1
    parameter logic [7:0]  OP_LB   = 8'h20,
    parameter logic [7:0]  OP_LBU  = 8'h24,
    parameter logic [7:0]  OP_LH   = 8'h21,
    parameter logic [7:0]  OP_LHU  = 8'h25,
    parameter logic [7:0]  OP_LW   = 8'h23,
    parameter logic [7:0]  OP_SB   = 8'h28,
    parameter logic [7:0]  OP_SH   = 8'h29,
    parameter logic [7:0]  OP_SW   = 8'h2B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        whilo_i,
    output logic        d_req_o,
    output logic        d_we_o,
    output logic [31:0] d_addr_o,
    output logic [3:0]  d_sel_o,
    output logic [31:0] d_wdata_o,
    input  logic        d_ack_i,
    input  logic [31:0] d_rdata_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        whilo_o,
    output logic        stallreq_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    // Abort fires on the BUSY cycle whose increment would reach TIMEOUT,
    // so the bus sees exactly TIMEOUT BUSY cycles.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [31:0] rdata_q;
    logic        load_q;
    logic        signed_q;
    size_t       size_q;
    logic [1:0]  addr_lo_q;

    // Operation decode
    logic  is_mem;
    logic  is_load;
    logic  is_signed;
    size_t size;

    always_comb begin
        is_mem    = 1'b1;
        is_load   = 1'b0;
        is_signed = 1'b0;
        size      = SZ_W;
        case (aluop_i)
            OP_LB:   begin is_load = 1'b1; is_signed = 1'b1; size = SZ_B; end
            OP_LBU:  begin is_load = 1'b1;                   size = SZ_B; end
            OP_LH:   begin is_load = 1'b1; is_signed = 1'b1; size = SZ_H; end
            OP_LHU:  begin is_load = 1'b1;                   size = SZ_H; end
            OP_LW:   begin is_load = 1'b1;                   size = SZ_W; end
            OP_SB:   size = SZ_B;
            OP_SH:   size = SZ_H;
            OP_SW:   size = SZ_W;
            default: is_mem = 1'b0;
        endcase
    end

    // Alignment, byte enables and lane-replicated store data
    logic        aligned;
    logic [3:0]  sel_next;
    logic [31:0] wdata_next;

    always_comb begin
        case (size)
            SZ_B: begin
                aligned    = 1'b1;
                sel_next   = 4'b0001 << mem_addr_i[1:0];
                wdata_next = {4{reg2_i[7:0]}};
            end
            SZ_H: begin
                aligned    = ~mem_addr_i[0];
                sel_next   = 4'b0011 << {mem_addr_i[1], 1'b0};
                wdata_next = {2{reg2_i[15:0]}};
            end
            default: begin
                aligned    = (mem_addr_i[1:0] == 2'b00);
                sel_next   = 4'hF;
                wdata_next = reg2_i;
            end
        endcase
    end

    // Load lane selection and extension, using the request-time attributes
    logic [31:0] lane;
    logic [31:0] ext_data;

    always_comb begin
        lane = d_rdata_i >> {addr_lo_q, 3'b000};
        case (size_q)
            SZ_B:    ext_data = {{24{signed_q & lane[7]}}, lane[7:0]};
            SZ_H:    ext_data = {{16{signed_q & lane[15]}}, lane[15:0]};
            default: ext_data = d_rdata_i;
        endcase
    end

    // Sequential control
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            d_req_o   <= 1'b0;
            d_we_o    <= 1'b0;
            d_addr_o  <= '0;
            d_sel_o   <= '0;
            d_wdata_o <= '0;
            bus_err_o <= 1'b0;
            rdata_q   <= '0;
            load_q    <= 1'b0;
            signed_q  <= 1'b0;
            size_q    <= SZ_W;
            addr_lo_q <= '0;
        end else begin
            bus_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (is_mem && aligned) begin
                        state     <= BUSY;
                        cnt       <= '0;
                        d_req_o   <= 1'b1;
                        d_we_o    <= ~is_load;
                        d_addr_o  <= {mem_addr_i[31:2], 2'b00};
                        d_sel_o   <= sel_next;
                        d_wdata_o <= wdata_next;
                        load_q    <= is_load;
                        signed_q  <= is_signed;
                        size_q    <= size;
                        addr_lo_q <= mem_addr_i[1:0];
                    end
                end
                BUSY: begin
                    cnt <= cnt + 8'd1;
                    // An ack on the last allowed cycle wins over the abort
                    if (d_ack_i) begin
                        state   <= DONE;
                        d_req_o <= 1'b0;
                        d_we_o  <= 1'b0;
                        if (load_q)
                            rdata_q <= ext_data;
                    end else if (cnt == TO_LAST) begin
                        state     <= DONE;
                        d_req_o   <= 1'b0;
                        d_we_o    <= 1'b0;
                        bus_err_o <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Write-back and hold; bus_err_o doubles as the "aborted" flag in DONE
    always_comb begin
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = wdata_i;
        hi_o       = hi_i;
        lo_o       = lo_i;
        whilo_o    = whilo_i;
        stallreq_o = 1'b0;
        misalign_o = 1'b0;
        if (!rst) begin
            wreg_o = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mem) begin
                        wreg_o = 1'b0;
                        if (aligned)
                            stallreq_o = 1'b1;
                        else
                            misalign_o = 1'b1;
                    end
                end
                BUSY: begin
                    wreg_o     = 1'b0;
                    stallreq_o = 1'b1;
                end
                DONE: begin
                    wreg_o = load_q & ~bus_err_o & wreg_i;
                    if (load_q)
                        wdata_o = rdata_q;
                end
                default: wreg_o = 1'b0;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the number of BUSY cycles without d_ack_i before abort.
REQ-002 SHALL have parameters OP_LB/OP_LBU/OP_LH/OP_LHU/OP_LW/OP_SB/OP_SH/OP_SW, defaults 8'h20/8'h24/8'h21/8'h25/8'h23/8'h28/8'h29/8'h2B, the load/store aluop codes.
REQ-003 clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 aluop_i  in  8  operation code from the execute stage.
REQ-006 mem_addr_i  in  32  effective address from the execute stage.
REQ-007 reg2_i  in  32  store data.
REQ-008 wd_i, wreg_i, wdata_i  in  5/1/32  register-write destination, enable and data, passed through for non-memory ops.
REQ-009 hi_i, lo_i, whilo_i  in  32/32/1  HI/LO write bundle, passed through unchanged.
REQ-010 d_req_o, d_we_o  out  1/1  data-bus request and write strobe.
REQ-011 d_addr_o  out  32  word address: mem_addr_i with [1:0] forced to 0.
REQ-012 d_sel_o  out  4  byte enables; bit i selects bits 8i+7:8i (little-endian).
REQ-013 d_wdata_o  out  32  store data, replicated to every byte/halfword lane.
REQ-014 d_ack_i, d_rdata_i  in  1/32  bus completion strobe and read data.
REQ-015 wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o  out  5/1/32/32/32/1  write-back bundle.
REQ-016 stallreq_o  out  1  pipeline hold request.
REQ-017 misalign_o, bus_err_o  out  1/1  one-cycle exception pulses.

Function
REQ-018 Non-memory aluop: all write-back outputs SHALL equal their inputs combinationally, with stallreq_o=0 and no bus activity.
REQ-019 FSM states SHALL be IDLE, BUSY and DONE.
REQ-020 IDLE with an aligned memory op: stallreq_o=1 combinationally; next edge registers address, sel, we and wdata, sets d_req_o=1 and moves to BUSY.
REQ-021 Alignment rule: halfword needs addr[0]=0; word needs addr[1:0]=0.
REQ-022 Misaligned op: no request is issued; misalign_o=1 and wreg_o=0 in that same cycle; stallreq_o=0; state stays IDLE.
REQ-023 BUSY: d_req_o, d_we_o, d_addr_o, d_sel_o and d_wdata_o SHALL be held stable; stallreq_o=1.
REQ-024 BUSY with d_ack_i=1: load data is captured with extension applied; d_req_o drops on the next edge; state moves to DONE.
REQ-025 DONE lasts exactly one cycle: stallreq_o=0.
REQ-026 DONE write-back for a load: wreg_o=wreg_i, wdata_o=captured data.
REQ-027 DONE write-back for a store: wreg_o=0.
REQ-028 DONE always returns to IDLE.
REQ-029 Byte sel SHALL be 4'b0001 shifted left by addr[1:0]; halfword sel SHALL be 4'b0011 shifted left by addr[1]*2; word sel SHALL be 4'hF.
REQ-030 Load extension: LB/LH sign-extend the selected lane; LBU/LHU zero-extend it.
REQ-031 A 8-bit counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-032 If the counter reaches TIMEOUT with no ack: abort, bus_err_o=1 for one cycle, go to DONE with wreg_o=0.
REQ-033 d_ack_i outside BUSY SHALL be ignored.
REQ-034 Minimum latency: op cycle 0, request cycles 1.., result in DONE; stallreq_o is high for 2 cycles.
REQ-035 While stallreq_o=1, all *_i inputs SHALL be held stable by the upstream stage; the block does not sample them again.

Reset
REQ-036 rst=0 SHALL asynchronously force state IDLE, counter 0, d_req_o=0, d_we_o=0, d_sel_o=0, misalign_o=0, bus_err_o=0 and the captured data to 0.
REQ-037 Reset during BUSY SHALL drop d_req_o immediately; a late ack after reset SHALL be ignored.
REQ-038 While rst=0, stallreq_o=0 and wreg_o=0.

Verification
REQ-039 LW addr 0x100, ack in the second BUSY cycle, rdata 0xDEADBEEF -> d_sel_o=4'hF, stall for 3 cycles, then DONE with wdata_o=0xDEADBEEF and wreg_o=1.
REQ-040 LB addr 0x103, rdata 0x80112233 -> d_sel_o=4'b1000, wdata_o=0xFFFFFF80; the same access with LBU -> 0x00000080.
REQ-041 SH addr 0x202, reg2_i=0x0000ABCD -> d_we_o=1, d_sel_o=4'b1100, d_wdata_o=0xABCDABCD, wreg_o=0 in DONE.
REQ-042 LW addr 0x101 -> misalign_o pulse, no d_req_o, stallreq_o=0, wreg_o=0.
REQ-043 LW with d_ack_i never asserted, TIMEOUT=4 -> bus_err_o pulse after 4 BUSY cycles, DONE with wreg_o=0, return to IDLE.
REQ-044 rst asserted mid-BUSY, then ack arrives after release -> d_req_o=0 immediately, ack ignored, state IDLE.
